// File: rtl/wave_pkg.sv
// Shared types and helpers for the waveform capture / display pair.
// Holds capture FSM encodings, buffer geometry and the offset-binary conversion.
package wave_pkg;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } cap_state_e;

    localparam int SAMPLES_PER_BUF = 256;
    localparam int RAM_ADDR_W      = 9;
    localparam int RAM_DATA_W      = 8;

    // Takes the top byte of a signed sample and returns it as offset binary,
    // so the most negative value maps to 0 and zero maps to 8'h80.
    function automatic logic [RAM_DATA_W-1:0] to_offset_bin(
        input logic [RAM_DATA_W-1:0] msbyte
    );
        return {~msbyte[RAM_DATA_W-1], msbyte[RAM_DATA_W-2:0]};
    endfunction

endpackage

// File: rtl/wave_capture_zero_cross.sv
// zero_cross_detect: keeps the previously accepted sample and flags a rising
// zero crossing (previous negative, current >= 0).
// Ports:
//   clk, reset     clock, async active-high reset
//   sample_en_i    accept sample_i this cycle (also updates prev_sample)
//   clear_i        force prev_sample to 0 (takes priority over sample_en_i)
//   sample_i       signed sample
//   trig_o         crossing seen on the sample accepted this cycle
module zero_cross_detect #(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_en_i,
    input  logic                clear_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    output logic                trig_o
);

    logic [SAMPLE_W-1:0] prev_q;
    logic [SAMPLE_W-1:0] prev_d;

    always_comb begin
        prev_d = prev_q;
        if (clear_i) begin
            prev_d = '0;
        end else if (sample_en_i) begin
            prev_d = sample_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // Compare against the registered previous sample so the crossing sample
    // itself can be written on the very next cycle.
    assign trig_o = sample_en_i & prev_q[SAMPLE_W-1] & ~sample_i[SAMPLE_W-1];

endmodule

// File: rtl/wave_capture.sv
// wave_capture: writer side of the double-buffered 512x8 waveform RAM.
// Arms on a rising zero crossing, writes 256 samples into the buffer the
// display is not reading, then flips read_index while the display is idle.
// Optional macro CAPTURE_TIMEOUT_EN: force a trigger after TIMEOUT_SAMPLES
// accepted samples in ARMED without a crossing.
// Ports:
//   clk, reset          clock, async active-high reset
//   new_sample_ready    strobe: new_sample_in valid this cycle
//   new_sample_in       signed sample
//   wave_display_idle   display is not fetching from RAM
//   write_address       {~read_index, offset}
//   write_enable        single-cycle RAM write strobe
//   write_sample        offset-binary top byte of the sample
//   read_index          buffer the display reads
module wave_capture
    import wave_pkg::*;
#(
    parameter int SAMPLE_W        = 16,
    parameter int TIMEOUT_SAMPLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_sample_ready,
    input  logic [SAMPLE_W-1:0]   new_sample_in,
    input  logic                  wave_display_idle,
    output logic [RAM_ADDR_W-1:0] write_address,
    output logic                  write_enable,
    output logic [RAM_DATA_W-1:0] write_sample,
    output logic                  read_index
);

    localparam int CNT_W = $clog2(SAMPLES_PER_BUF);

    cap_state_e            state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ri_q, ri_d;
    logic                  we_q, we_d;
    logic [RAM_ADDR_W-1:0] addr_q, addr_d;
    logic [RAM_DATA_W-1:0] data_q, data_d;

    logic                  armed_accept;
    logic                  flip;
    logic                  zc_trig;
    logic                  start;
    logic [RAM_DATA_W-1:0] sample_ob;

    assign armed_accept = new_sample_ready && (state_q == ARMED);
    assign flip         = wave_display_idle && (state_q == WAIT);
    assign sample_ob    = to_offset_bin(new_sample_in[SAMPLE_W-1 -: RAM_DATA_W]);

    zero_cross_detect #(
        .SAMPLE_W (SAMPLE_W)
    ) u_zc (
        .clk         (clk),
        .reset       (reset),
        .sample_en_i (armed_accept),
        .clear_i     (flip),
        .sample_i    (new_sample_in),
        .trig_o      (zc_trig)
    );

`ifdef CAPTURE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_SAMPLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_hit;

    // Counter is held at zero outside ARMED, so every ARMED entry starts fresh.
    assign to_hit = armed_accept && (to_cnt_q == TO_W'(TIMEOUT_SAMPLES - 1));

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q != ARMED) begin
            to_cnt_d = '0;
        end else if (armed_accept) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign start = zc_trig | to_hit;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_SAMPLES == 0);
    assign start          = zc_trig;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ri_d    = ri_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            ARMED: begin
                // The triggering sample is stored at offset 0.
                if (start) begin
                    we_d    = 1'b1;
                    addr_d  = {~ri_q, {CNT_W{1'b0}}};
                    data_d  = sample_ob;
                    count_d = CNT_W'(1);
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (new_sample_ready) begin
                    we_d    = 1'b1;
                    addr_d  = {~ri_q, count_q};
                    data_d  = sample_ob;
                    count_d = count_q + 1'b1;
                    if (&count_q) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Buffer swap only during display blanking.
                if (wave_display_idle) begin
                    ri_d    = ~ri_q;
                    state_d = ARMED;
                end
            end
            default: begin
                state_d = ARMED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARMED;
            count_q <= '0;
            ri_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= RAM_ADDR_W'(9'h100);
            data_q  <= RAM_DATA_W'(8'h80);
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ri_q    <= ri_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign write_address = addr_q;
    assign write_enable  = we_q;
    assign write_sample  = data_q;
    assign read_index    = ri_q;

endmodule

// File: tb/tb_wave_capture.sv
// Self-checking bench for wave_capture: expected RAM writes are queued as
// samples are driven and compared as write strobes appear.
module tb_wave_capture;

    logic        clk;
    logic        reset;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    typedef struct packed {
        logic [8:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  wr_cnt   = 0;

    wave_capture #(
        .SAMPLE_W        (16),
        .TIMEOUT_SAMPLES (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ob(input logic [15:0] s);
        return {~s[15], s[14:8]};
    endfunction

    // Scoreboard side: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            wr_t e;
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%h data=%h", write_address, write_sample);
            end else begin
                e = exp_q.pop_front();
                if (write_address !== e.a || write_sample !== e.d) begin
                    failures++;
                    $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                             write_address, write_sample, e.a, e.d);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] s);
        new_sample_ready = 1'b1;
        new_sample_in    = s;
        tick();
        new_sample_ready = 1'b0;
        repeat (3) tick();
    endtask

    task automatic push(input logic [8:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        exp_q.delete();
    endtask

    task automatic test_reset;
        new_sample_ready  = 1'b0;
        new_sample_in     = '0;
        wave_display_idle = 1'b0;
        reset             = 1'b1;
        #1;
        checks++;
        if (write_enable !== 1'b0 || write_address !== 9'h100 ||
            write_sample !== 8'h80 || read_index !== 1'b0) begin
            failures++;
            $display("FAIL reset_vals we=%b addr=%h data=%h ri=%b exp 0/100/80/0",
                     write_enable, write_address, write_sample, read_index);
        end
        tick();
        reset = 1'b0;
        repeat (20) begin
            tick();
            checks++;
            if (write_enable !== 1'b0) begin
                failures++;
                $display("FAIL idle_we got=%b exp=0", write_enable);
            end
        end
        checks++;
        if (read_index !== 1'b0 || write_address !== 9'h100) begin
            failures++;
            $display("FAIL idle_state ri=%b addr=%h exp 0/100", read_index, write_address);
        end
    endtask

    task automatic test_capture;
        int base;
        do_reset();
        base = wr_cnt;
        send(16'(-5));
        send(16'(-1));
        for (int i = 0; i < 256; i++) begin
            push({1'b1, 8'(i)}, ob(16'(i)));
            send(16'(i));
        end
        tick();
        checks++;
        if (wr_cnt - base !== 256 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL capture_count got=%0d exp=256 left=%0d", wr_cnt - base, exp_q.size());
        end
    endtask

    task automatic test_timeout_ramp;
        int base;
        int exp_n;
        do_reset();
        base  = wr_cnt;
        exp_n = 0;
        for (int i = 0; i < 40; i++) begin
`ifdef CAPTURE_TIMEOUT_EN
            if (i >= 15) begin
                push({1'b1, 8'(i - 15)}, ob(16'(i)));
                exp_n++;
            end
`endif
            send(16'(i));
        end
        tick();
        checks++;
        if (wr_cnt - base !== exp_n || exp_q.size() != 0) begin
            failures++;
            $display("FAIL ramp_writes got=%0d exp=%0d", wr_cnt - base, exp_n);
        end
    endtask

    task automatic test_back_to_back;
        int          base;
        logic [15:0] s;
        do_reset();
        base = wr_cnt;
        send(16'(-1));
        for (int i = 0; i < 256; i++) begin
            s = 16'(i * 128);
            push({1'b1, 8'(i)}, ob(s));
            send(s);
        end
        for (int i = 0; i < 50; i++) begin
            send((i % 2 == 0) ? 16'(-100) : 16'(100));
        end
        checks++;
        if (read_index !== 1'b0 || wr_cnt - base !== 256) begin
            failures++;
            $display("FAIL wait_hold ri=%b writes=%0d exp 0/256", read_index, wr_cnt - base);
        end
        // Idle and a negative sample in the same WAIT cycle: only the flip.
        wave_display_idle = 1'b1;
        new_sample_ready  = 1'b1;
        new_sample_in     = 16'(-7);
        tick();
        new_sample_ready  = 1'b0;
        wave_display_idle = 1'b0;
        checks++;
        if (read_index !== 1'b1) begin
            failures++;
            $display("FAIL flip got ri=%b exp=1", read_index);
        end
        tick();
        send(16'h0000);
        send(16'(-1));
        for (int i = 0; i < 100; i++) begin
            s = (i == 0) ? 16'h0000 : 16'(i * 256 - 32768);
            push({1'b0, 8'(i)}, ob(s));
            send(s);
        end
        checks++;
        if (exp_q.size() != 0 || read_index !== 1'b1) begin
            failures++;
            $display("FAIL low_buf left=%0d ri=%b exp 0/1", exp_q.size(), read_index);
        end
    endtask

    task automatic test_async_reset;
        new_sample_ready = 1'b1;
        new_sample_in    = 16'h1234;
        @(posedge clk);
        #1;
        new_sample_ready = 1'b0;
        checks++;
        if (write_enable !== 1'b1 || write_address !== 9'h064 || write_sample !== ob(16'h1234)) begin
            failures++;
            $display("FAIL pre_reset we=%b addr=%h data=%h exp 1/064/%h",
                     write_enable, write_address, write_sample, ob(16'h1234));
        end
        reset = 1'b1;
        #1;
        checks++;
        if (write_enable !== 1'b0 || write_address !== 9'h100 ||
            write_sample !== 8'h80 || read_index !== 1'b0) begin
            failures++;
            $display("FAIL async_reset we=%b addr=%h data=%h ri=%b exp 0/100/80/0",
                     write_enable, write_address, write_sample, read_index);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_crossing;
        send(16'h8000);
        push(9'h100, 8'h80);
        send(16'h0000);
        tick();
        checks++;
        if (exp_q.size() != 0 || write_address !== 9'h100 || write_sample !== 8'h80) begin
            failures++;
            $display("FAIL crossing left=%0d addr=%h data=%h exp 0/100/80",
                     exp_q.size(), write_address, write_sample);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_timeout_ramp();
        test_back_to_back();
        test_async_reset();
        test_crossing();
        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
